frame_ram_arbiter: RTL and testbench

FRAME_RAM_ARBITER -- requirements
Module: frame_ram_arbiter

---
 rtl/frame_ram_arbiter_pkg.sv | 30 +++
 rtl/frame_ram_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_frame_ram_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_ram_arbiter_pkg.sv
// Shared frame-buffer definitions used by the game logic, the renderer and the RAM arbiter.
// The ST_CLEAR encoding exists only when FRAME_CLEAR_EN is defined.
package frame_ram_arbiter_pkg;

  localparam int ROW_W  = 60;
  localparam int Y_MAX  = 33;
  localparam int X_MAX  = 59;
  localparam int ROW_AW = 6;

  typedef logic [ROW_AW-1:0] row_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_WAIT = 2'd2
`ifdef FRAME_CLEAR_EN
    , ST_CLEAR = 2'd3
`endif
  } state_e;

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_GAME = 1'b1
  } owner_e;

  function automatic logic row_oob(input row_t row, input int y_max);
    return int'(row) > y_max;
  endfunction

endpackage

// File: rtl/frame_ram_arbiter.sv
// Single-transaction arbiter between the display reader and the game logic for an external frame RAM.
// Define FRAME_CLEAR_EN to add the frame clear engine (clear_start / clear_busy).
module frame_ram_arbiter
  import frame_ram_arbiter_pkg::*;
#(
  parameter int ROW_W      = frame_ram_arbiter_pkg::ROW_W,
  parameter int Y_MAX      = frame_ram_arbiter_pkg::Y_MAX,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FRAME_CLEAR_EN
  input  logic             clear_start,
  output logic             clear_busy,
`endif
  input  logic             disp_req,
  input  logic [5:0]       disp_row,
  output logic             disp_gnt,
  output logic [ROW_W-1:0] disp_data,
  output logic             disp_valid,
  input  logic             game_req,
  input  logic             game_we,
  input  logic [5:0]       game_row,
  input  logic [ROW_W-1:0] game_wdata,
  output logic             game_gnt,
  output logic [ROW_W-1:0] game_rdata,
  output logic             game_rvalid,
  output logic [5:0]       ram_addr,
  output logic             ram_we,
  output logic [ROW_W-1:0] ram_wdata,
  input  logic [ROW_W-1:0] ram_rdata,
  output logic             oob_err
);

  localparam int WAIT_W = $clog2(STARVE_MAX + 1);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic               we_q, we_d;
  logic               oob_q, oob_d;
  row_t               cnt_q, cnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               run_q;
  row_t               ram_addr_q, ram_addr_d;
  logic               ram_we_q, ram_we_d;
  logic [ROW_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [ROW_W-1:0]   disp_data_q, disp_data_d;
  logic [ROW_W-1:0]   game_rdata_q, game_rdata_d;
  logic               disp_valid_q, disp_valid_d;
  logic               game_valid_q, game_valid_d;

  logic               starved;
  logic               sel_game;
  row_t               req_row;
  logic               req_we;
  logic               req_oob;

  assign starved = (wait_q == WAIT_W'(STARVE_MAX));

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    oob_d        = oob_q;
    cnt_d        = cnt_q;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = 1'b0;
    ram_wdata_d  = ram_wdata_q;
    disp_data_d  = disp_data_q;
    game_rdata_d = game_rdata_q;
    disp_valid_d = 1'b0;
    game_valid_d = 1'b0;
    disp_gnt     = 1'b0;
    game_gnt     = 1'b0;
    sel_game     = 1'b0;
    req_row      = disp_row;
    req_we       = 1'b0;
    req_oob      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // run_q holds off grants until the first edge after reset release.
        if (run_q) begin
`ifdef FRAME_CLEAR_EN
          if (clear_start) begin
            state_d     = ST_CLEAR;
            cnt_d       = '0;
            ram_addr_d  = '0;
            ram_we_d    = 1'b1;
            ram_wdata_d = '0;
          end else
`endif
          if (disp_req || game_req) begin
            sel_game = game_req && (starved || !disp_req);
            disp_gnt = !sel_game;
            game_gnt = sel_game;
            req_row  = sel_game ? game_row : disp_row;
            req_we   = sel_game && game_we;
            req_oob  = row_oob(req_row, Y_MAX);
            owner_d  = sel_game ? OWN_GAME : OWN_DISP;
            we_d     = req_we;
            oob_d    = req_oob;
            cnt_d    = '0;
            state_d  = ST_ISSUE;
            // Out-of-range rows never touch the RAM address or write strobe.
            if (!req_oob) begin
              ram_addr_d = req_row;
              ram_we_d   = req_we;
              if (req_we) ram_wdata_d = game_wdata;
            end
          end
        end
      end

      ST_ISSUE: begin
        state_d = we_q ? ST_IDLE : ST_RD_WAIT;
        cnt_d   = '0;
      end

      ST_RD_WAIT: begin
        if (cnt_q == row_t'(RD_LAT - 1)) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_GAME) begin
            game_rdata_d = oob_q ? '0 : ram_rdata;
            game_valid_d = 1'b1;
          end else begin
            disp_data_d  = oob_q ? '0 : ram_rdata;
            disp_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + row_t'(1);
        end
      end

`ifdef FRAME_CLEAR_EN
      ST_CLEAR: begin
        if (cnt_q == row_t'(Y_MAX)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d       = cnt_q + row_t'(1);
          ram_addr_d  = cnt_q + row_t'(1);
          ram_we_d    = 1'b1;
          ram_wdata_d = '0;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (game_gnt) begin
      wait_d = '0;
    end else if (game_req && !starved) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_DISP;
      we_q         <= 1'b0;
      oob_q        <= 1'b0;
      cnt_q        <= '0;
      wait_q       <= '0;
      run_q        <= 1'b0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      disp_data_q  <= '0;
      game_rdata_q <= '0;
      disp_valid_q <= 1'b0;
      game_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      oob_q        <= oob_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      run_q        <= 1'b1;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      disp_data_q  <= disp_data_d;
      game_rdata_q <= game_rdata_d;
      disp_valid_q <= disp_valid_d;
      game_valid_q <= game_valid_d;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_wdata   = ram_wdata_q;
  assign disp_data   = disp_data_q;
  assign disp_valid  = disp_valid_q;
  assign game_rdata  = game_rdata_q;
  assign game_rvalid = game_valid_q;
  assign oob_err     = (state_q == ST_ISSUE) && oob_q;
`ifdef FRAME_CLEAR_EN
  assign clear_busy  = (state_q == ST_CLEAR);
`endif

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Scoreboard bench for frame_ram_arbiter with a behavioural RAM of latency RD_LAT.
// Expectations are queued at each grant and retired when the DUT produces the matching event.
module tb_frame_ram_arbiter;

  localparam int ROW_W      = 60;
  localparam int Y_MAX      = 33;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 8;

  typedef struct {
    logic [63:0] data;
    logic [5:0]  addr;
    int          cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             disp_req = 1'b0;
  logic [5:0]       disp_row = '0;
  logic             disp_gnt;
  logic [ROW_W-1:0] disp_data;
  logic             disp_valid;
  logic             game_req = 1'b0;
  logic             game_we = 1'b0;
  logic [5:0]       game_row = '0;
  logic [ROW_W-1:0] game_wdata = '0;
  logic             game_gnt;
  logic [ROW_W-1:0] game_rdata;
  logic             game_rvalid;
  logic [5:0]       ram_addr;
  logic             ram_we;
  logic [ROW_W-1:0] ram_wdata;
  logic [ROW_W-1:0] ram_rdata;
  logic             oob_err;
`ifdef FRAME_CLEAR_EN
  logic             clear_start = 1'b0;
  logic             clear_busy;
`endif

  frame_ram_arbiter #(
    .ROW_W(ROW_W), .Y_MAX(Y_MAX), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef FRAME_CLEAR_EN
    .clear_start(clear_start), .clear_busy(clear_busy),
`endif
    .disp_req(disp_req), .disp_row(disp_row), .disp_gnt(disp_gnt),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .game_req(game_req), .game_we(game_we), .game_row(game_row),
    .game_wdata(game_wdata), .game_gnt(game_gnt), .game_rdata(game_rdata),
    .game_rvalid(game_rvalid), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [ROW_W-1:0] init_val(input int i);
    if (i == 5) return 60'h0F;
    return {12'(i * 3 + 1), 48'hC0FF_EE00_1234};
  endfunction

  // Behavioural frame RAM: writes land on the edge, reads arrive RD_LAT cycles after the address.
  logic             ram_load = 1'b0;
  logic [ROW_W-1:0] mem [64];
  logic [ROW_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    rd_pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[RD_LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: queues of expected events plus a reference copy of the frame contents.
  exp_t             disp_q[$];
  exp_t             game_q[$];
  exp_t             wr_q[$];
  int               oob_q[$];
  logic [ROW_W-1:0] ref_mem [64];
  int               model_wait = 0;
  exp_t             e;

  function automatic exp_t mk_read(input logic [5:0] row, input int c);
    exp_t r;
    r.addr = row;
    r.data = (int'(row) > Y_MAX) ? 64'd0 : 64'(ref_mem[row]);
    r.cyc  = c + RD_LAT + 2;
    return r;
  endfunction

  always @(negedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    end
    if (disp_valid) begin
      check("disp_valid_expected", 64'(disp_q.size() != 0), 64'd1);
      if (disp_q.size() != 0) begin
        e = disp_q.pop_front();
        check("disp_data", 64'(disp_data), e.data);
        check("disp_valid_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (game_rvalid) begin
      check("game_rvalid_expected", 64'(game_q.size() != 0), 64'd1);
      if (game_q.size() != 0) begin
        e = game_q.pop_front();
        check("game_rdata", 64'(game_rdata), e.data);
        check("game_rvalid_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (ram_we) begin
      check("ram_we_expected", 64'(wr_q.size() != 0), 64'd1);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        check("ram_addr", 64'(ram_addr), 64'(e.addr));
        check("ram_wdata", 64'(ram_wdata), e.data);
        check("ram_we_cycle", 64'(cyc), 64'(e.cyc));
        ref_mem[e.addr] = ROW_W'(e.data);
      end
    end
    if (oob_err) begin
      check("oob_err_expected", 64'(oob_q.size() != 0), 64'd1);
      if (oob_q.size() != 0) check("oob_err_cycle", 64'(cyc), 64'(oob_q.pop_front()));
    end

    if (rst) begin
      if (disp_gnt || game_gnt) check("single_gnt", 64'(disp_gnt && game_gnt), 64'd0);
      if (disp_gnt && game_req) check("disp_win_not_starved", 64'(model_wait == STARVE_MAX), 64'd0);
      if (game_gnt && disp_req) check("game_win_starved", 64'(model_wait), 64'(STARVE_MAX));
      if (disp_gnt) begin
        disp_q.push_back(mk_read(disp_row, cyc));
        if (int'(disp_row) > Y_MAX) oob_q.push_back(cyc + 1);
      end
      if (game_gnt) begin
        if (int'(game_row) > Y_MAX) oob_q.push_back(cyc + 1);
        if (!game_we) begin
          game_q.push_back(mk_read(game_row, cyc));
        end else if (int'(game_row) <= Y_MAX) begin
          e.addr = game_row;
          e.data = 64'(game_wdata);
          e.cyc  = cyc + 1;
          wr_q.push_back(e);
        end
      end
      if (game_gnt) model_wait = 0;
      else if (game_req && model_wait < STARVE_MAX) model_wait++;
    end else begin
      model_wait = 0;
    end
  end

  task automatic disp_access(input logic [5:0] row);
    int n = 0;
    disp_row = row;
    disp_req = 1'b1;
    do begin @(negedge clk); n++; end while (!disp_gnt && n < 200);
    check("disp_gnt_seen", 64'(disp_gnt), 64'd1);
    @(posedge clk); #1;
    disp_req = 1'b0;
  endtask

  task automatic game_access(input logic we, input logic [5:0] row, input logic [ROW_W-1:0] wdata);
    int n = 0;
    game_we    = we;
    game_row   = row;
    game_wdata = wdata;
    game_req   = 1'b1;
    do begin @(negedge clk); n++; end while (!game_gnt && n < 200);
    check("game_gnt_seen", 64'(game_gnt), 64'd1);
    @(posedge clk); #1;
    game_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((disp_q.size() + game_q.size() + wr_q.size() + oob_q.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 64'(disp_q.size() + game_q.size() + wr_q.size() + oob_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_disp_gnt"},   64'(disp_gnt),   64'd0);
    check({tag, "_game_gnt"},   64'(game_gnt),   64'd0);
    check({tag, "_disp_valid"}, 64'(disp_valid), 64'd0);
    check({tag, "_game_rvalid"},64'(game_rvalid),64'd0);
    check({tag, "_ram_we"},     64'(ram_we),     64'd0);
    check({tag, "_ram_addr"},   64'(ram_addr),   64'd0);
    check({tag, "_ram_wdata"},  64'(ram_wdata),  64'd0);
    check({tag, "_disp_data"},  64'(disp_data),  64'd0);
    check({tag, "_game_rdata"}, 64'(game_rdata), 64'd0);
    check({tag, "_oob_err"},    64'(oob_err),    64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int busy;
    int c0;
    // Reset with requests pending: nothing may be granted.
    ram_load = 1'b1;
    disp_req = 1'b1;
    game_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 ram_load = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    disp_req = 1'b0;
    game_req = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Display read of row 5: data 0x0F at gnt + 4.
    disp_access(6'd5);
    drain();

    // Game write of the last row, then read it back.
    game_access(1'b1, 6'd33, 60'h1);
    game_access(1'b0, 6'd33, '0);
    drain();
    check("held_game_rdata", 64'(game_rdata), 64'h1);

    // Mixed traffic, including a simultaneous request pair (display wins).
    game_access(1'b1, 6'd0, 60'hABC_DEF0_1234_5678);
    fork
      disp_access(6'd0);
      game_access(1'b0, 6'd5, '0);
    join
    game_access(1'b1, 6'd12, 60'h5A5_5A5A_5A5A_5A5A);
    disp_access(6'd12);
    drain();
    check("held_disp_data", 64'(disp_data), 64'h5A5_5A5A_5A5A_5A5A);

    // Starvation: display holds its request; game must win once the wait saturates.
    disp_row = 6'd7;
    disp_req = 1'b1;
    game_access(1'b1, 6'd2, 60'h2222);
    n = 0;
    do begin @(negedge clk); n++; end while (!disp_gnt && n < 50);
    check("disp_resumes_after_game", 64'(disp_gnt), 64'd1);
    @(posedge clk); #1;
    disp_req = 1'b0;
    drain();
    disp_access(6'd2);
    drain();

    // Out-of-range rows: write dropped, read returns zero, oob_err pulses.
    game_access(1'b1, 6'd40, 60'hDEAD);
    disp_access(6'd63);
    game_access(1'b0, 6'd34, '0);
    drain();
    check("oob_read_zero", 64'(disp_data), 64'd0);

`ifdef FRAME_CLEAR_EN
    // Clear wins over a pending display request and zeroes rows 0..Y_MAX.
    disp_row    = 6'd3;
    disp_req    = 1'b1;
    clear_start = 1'b1;
    @(negedge clk);
    check("clear_blocks_gnt", 64'(disp_gnt), 64'd0);
    c0 = cyc;
    for (int i = 0; i <= Y_MAX; i++) begin
      e.addr = 6'(i);
      e.data = 64'd0;
      e.cyc  = c0 + 1 + i;
      wr_q.push_back(e);
    end
    @(posedge clk); #1;
    clear_start = 1'b0;
    busy = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (clear_busy) busy++;
    end while (!disp_gnt && n < 100);
    check("clear_busy_cycles", 64'(busy), 64'(Y_MAX + 1));
    check("gnt_after_clear_cycle", 64'(cyc), 64'(c0 + Y_MAX + 2));
    @(posedge clk); #1;
    disp_req = 1'b0;
    drain();
`else
    c0 = 0;
    busy = 0;
`endif

    // Reset during RD_WAIT aborts the read with no valid.
    disp_access(6'd9);
    @(posedge clk); #1;
    rst = 1'b0;
    disp_q.delete();
    @(negedge clk);
    check_outputs_zero("mid_reset");
    repeat (6) @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    disp_access(6'd9);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
